// File: rtl/init_pop_stream_if.sv
// Purpose : control + genome stream bundle between run controller, initialiser and RAM writer.
// Latency : n/a (wires only).
// Backpressure: genome_ready from the consumer holds genome_valid/data/idx stable.
// Ports   : start/seed/mode (run request), genome_data/idx/valid/ready (stream), busy/done (status).
interface init_pop_stream_if #(
  parameter int GENOME_BITS = 250,
  parameter int IDX_W       = 5
);
  logic                   start;
  logic [31:0]            seed;
  logic [1:0]             mode;
  logic [GENOME_BITS-1:0] genome_data;
  logic [IDX_W-1:0]       genome_idx;
  logic                   genome_valid;
  logic                   genome_ready;
  logic                   busy;
  logic                   done;

  // master: the initialiser (produces the genome stream)
  modport master (
    input  start, seed, mode, genome_ready,
    output genome_data, genome_idx, genome_valid, busy, done
  );

  // slave: controller/consumer side
  modport slave (
    output start, seed, mode, genome_ready,
    input  genome_data, genome_idx, genome_valid, busy, done
  );
endinterface

// File: rtl/init_pop_stream.sv
// Purpose : generates POP_SIZE genomes of GENOME_BITS from a 32-bit xorshift, streamed one per handshake.
// Latency : start->first valid CHUNKS+1 cycles (2*CHUNKS+1 in sparse mode); CHUNKS+1 spacing with ready high.
// Backpressure: genome held in PRESENT until genome_ready; generator frozen meanwhile.
// Ports   : clk, rst (async, active high); bus (master modport): start/seed/mode in,
//           genome_data/genome_idx/genome_valid out, genome_ready in, busy/done out.
module init_pop_stream #(
  parameter int POP_SIZE    = 30,
  parameter int GENOME_BITS = 250,
  parameter int CHUNK_W     = 8,
  parameter int IDX_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  init_pop_stream_if.master  bus
);

  localparam int CHUNKS = (GENOME_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] MODE_RAND   = 2'd0;
  localparam logic [1:0] MODE_ZEROS  = 2'd1;
  localparam logic [1:0] MODE_ONES   = 2'd2;
  localparam logic [1:0] MODE_SPARSE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [GENOME_BITS-1:0] data_q, data_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             mode_q, mode_d;
  // sparse mode: phase 0 draws the first half of the AND pair, phase 1 commits
  logic                   phase_q, phase_d;
  logic [CHUNK_W-1:0]     half_q, half_d;

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  logic [31:0]            lfsr_next;
  logic [CHUNK_W-1:0]     gen_chunk;
  logic [CHUNK_W-1:0]     fill_chunk;
  logic [GENOME_BITS-1:0] data_app;
  logic                   chunk_commit;
  logic                   last_chunk;
  logic                   last_genome;
  logic                   accept;
  logic                   gen_steps;

  assign lfsr_next    = xs_step(lfsr_q);
  assign gen_chunk    = lfsr_next[CHUNK_W-1:0];
  assign chunk_commit = (mode_q != MODE_SPARSE) || phase_q;
  assign last_chunk   = chunk_commit && (cnt_q == CNT_W'(CHUNKS - 1));
  assign last_genome  = (idx_q == IDX_W'(POP_SIZE - 1));
  assign accept       = (state_q == S_PRESENT) && bus.genome_ready;
  assign gen_steps    = (mode_q == MODE_RAND) || (mode_q == MODE_SPARSE);

  always_comb begin
    fill_chunk = gen_chunk;
    case (mode_q)
      MODE_RAND:   fill_chunk = gen_chunk;
      MODE_ZEROS:  fill_chunk = '0;
      MODE_ONES:   fill_chunk = '1;
      MODE_SPARSE: fill_chunk = half_q & gen_chunk;
      default:     fill_chunk = gen_chunk;
    endcase
  end

  // Shift-left-and-append; bits pushed past GENOME_BITS fall off the top,
  // so the first chunk ends up most significant.
  generate
    if (CHUNK_W >= GENOME_BITS) begin : g_narrow
      assign data_app = fill_chunk[GENOME_BITS-1:0];
    end else begin : g_wide
      assign data_app = {data_q[GENOME_BITS-CHUNK_W-1:0], fill_chunk};
    end
  endgenerate

  // State register and datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= 32'h1;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'd0;
      phase_q <= 1'b0;
      half_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      half_q  <= half_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_FILL;
      S_FILL:    if (last_chunk) state_d = S_PRESENT;
      S_PRESENT: if (accept) state_d = last_genome ? S_DONE : S_FILL;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    half_d  = half_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // an all-zero seed would lock the xorshift at zero forever
          lfsr_d  = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
          mode_d  = bus.mode;
          data_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          phase_d = 1'b0;
          half_d  = '0;
        end
      end
      S_FILL: begin
        if (gen_steps) lfsr_d = lfsr_next;
        if (chunk_commit) begin
          data_d  = data_app;
          cnt_d   = cnt_q + CNT_W'(1);
          phase_d = 1'b0;
        end else begin
          half_d  = gen_chunk;
          phase_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (accept && !last_genome) begin
          idx_d   = idx_q + IDX_W'(1);
          data_d  = '0;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.genome_valid = 1'b0;
    bus.busy         = 1'b1;
    bus.done         = 1'b0;
    case (state_q)
      S_IDLE:    bus.busy         = 1'b0;
      S_PRESENT: bus.genome_valid = 1'b1;
      S_DONE:    bus.done         = 1'b1;
      default:   ;
    endcase
  end

  assign bus.genome_data = data_q;
  assign bus.genome_idx  = idx_q;

endmodule
